// File: rtl/iecdrv_pkg.sv
// Shared definitions for the IEC drive ROM multiplexer.
//   SZ_*   : ROM size codes as presented on rom_sz.
//   tag_w  : width of the slot tag that names a client drive (at least 1 bit).
package iecdrv_pkg;

   localparam logic [1:0] SZ_8K  = 2'b00;
   localparam logic [1:0] SZ_16K = 2'b01;
   localparam logic [1:0] SZ_32K = 2'b11;

   // A single drive still needs one tag bit so the pipeline has a real field.
   function automatic int tag_w(input int drives);
      return (drives <= 1) ? 1 : $clog2(drives);
   endfunction

endpackage

// File: rtl/iecdrv_tag_pipe.sv
// Tag/valid delay line that travels alongside an issued ROM address.
//   clk, reset : clock, asynchronous active-high reset
//   flush      : clears every valid bit (aborted sweep)
//   in_vld     : an address is being issued this cycle
//   in_tag     : drive index of that address
//   out_vld    : tag at the end of the line is live
//   out_tag    : drive index whose ROM data is on mem_d now
module iecdrv_tag_pipe #(
   parameter int DEPTH = 2,
   parameter int TW    = 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          flush,
   input  logic          in_vld,
   input  logic [TW-1:0] in_tag,
   output logic          out_vld,
   output logic [TW-1:0] out_tag
);

   logic [DEPTH-1:0]         vld_pipe;
   logic [DEPTH-1:0][TW-1:0] tag_pipe;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vld_pipe <= '0;
         tag_pipe <= '0;
      end else begin
         for (int i = DEPTH-1; i > 0; i--) begin
            vld_pipe[i] <= vld_pipe[i-1];
            tag_pipe[i] <= tag_pipe[i-1];
         end
         vld_pipe[0] <= in_vld;
         tag_pipe[0] <= in_tag;
         // Flush also kills whatever would enter this cycle.
         if (flush) vld_pipe <= '0;
      end
   end

   assign out_vld = vld_pipe[DEPTH-1];
   assign out_tag = tag_pipe[DEPTH-1];

endmodule

// File: rtl/iecdrv_rom_mux.sv
// Time-multiplexes one shared drive ROM among DRIVES client drives.
// Each frame_stb starts a sweep: slot s walks 0..DRIVES+RDLAT+2, issuing
// drive k's (size-masked) address in slot k and capturing its data RDLAT
// cycles after the address is valid.
//   clk, reset   : clock, asynchronous active-high reset
//   frame_stb    : one-cycle sweep start
//   drv_en       : per-drive capture enable
//   rom_sz       : ROM size code, stdrom : standard 16K ROM selected
//   drv_addr     : packed per-drive addresses (drive k at [k*AW +: AW])
//   mem_a/mem_d  : shared ROM address (registered) / read data
//   drv_data     : packed per-drive captured data, drv_valid : capture pulses
//   sweep_done   : pulse at completion of an unaborted sweep
//   overrun      : sticky abort flag, overrun_clr clears it
module iecdrv_rom_mux
   import iecdrv_pkg::*;
#(
   parameter int DRIVES = 2,
   parameter int AW     = 15,
   parameter int DW     = 8,
   parameter int RDLAT  = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 frame_stb,
   input  logic [DRIVES-1:0]    drv_en,
   input  logic [1:0]           rom_sz,
   input  logic                 stdrom,
   input  logic [DRIVES*AW-1:0] drv_addr,
   output logic [AW-1:0]        mem_a,
   input  logic [DW-1:0]        mem_d,
   output logic [DRIVES*DW-1:0] drv_data,
   output logic [DRIVES-1:0]    drv_valid,
   output logic                 sweep_done,
   output logic                 overrun,
   input  logic                 overrun_clr
);

   localparam int SAT = DRIVES + RDLAT + 2;
   localparam int CW  = $clog2(SAT + 1);
   localparam int TW  = tag_w(DRIVES);

   localparam logic [CW-1:0] S_SAT  = CW'(SAT);
   localparam logic [CW-1:0] S_LAST = CW'(SAT - 1);
   localparam logic [CW-1:0] S_DRV  = CW'(DRIVES);

   logic [CW-1:0] s;
   logic          busy, abort, issue;
   logic [AW-1:0] sel_addr;
   logic          cap_vld;
   logic [TW-1:0] cap_tag;

   // Size masking: 32K bit only with a 32K ROM, 16K bit with >=16K or stdrom.
   function automatic logic [AW-1:0] mask_addr(input logic [AW-1:0] a,
                                                input logic [1:0]    sz,
                                                input logic          std);
      logic [AW-1:0] m;
      m       = a;
      m[AW-1] = a[AW-1] & sz[1];
      m[AW-2] = a[AW-2] & (sz[0] | std);
      if (AW == 16) m[AW-1] = 1'b0;
      return m;
   endfunction

   // s == SAT is the idle state; anything below it is a sweep in flight.
   assign busy  = (s != S_SAT);
   assign abort = frame_stb & busy;
   // No issue on the restart edge so the flushed pipe stays empty.
   assign issue = ~frame_stb & (s < S_DRV);

   always_comb begin
      sel_addr = '0;
      for (int k = 0; k < DRIVES; k++)
         if (s == CW'(k)) sel_addr = drv_addr[k*AW +: AW];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)              s <= S_SAT;
      else if (frame_stb)     s <= '0;
      else if (s != S_SAT)    s <= s + CW'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)      mem_a <= '0;
      else if (issue) mem_a <= mask_addr(sel_addr, rom_sz, rom_sz == SZ_8K ? stdrom : stdrom);
   end

   // A strobe landing in the last busy slot aborts, so done is suppressed.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) sweep_done <= 1'b0;
      else       sweep_done <= (s == S_LAST) & ~frame_stb;
   end

   // Set has priority over clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)            overrun <= 1'b0;
      else if (abort)       overrun <= 1'b1;
      else if (overrun_clr) overrun <= 1'b0;
   end

   iecdrv_tag_pipe #(
      .DEPTH (RDLAT + 1),
      .TW    (TW)
   ) u_tag_pipe (
      .clk     (clk),
      .reset   (reset),
      .flush   (abort),
      .in_vld  (issue),
      .in_tag  (s[TW-1:0]),
      .out_vld (cap_vld),
      .out_tag (cap_tag)
   );

   for (genvar k = 0; k < DRIVES; k++) begin : g_drv
      logic          cap;
      logic [DW-1:0] data_q;
      logic          vld_q;

      // Data arriving on the abort edge belongs to the dead sweep.
      assign cap = cap_vld & (cap_tag == TW'(k)) & drv_en[k] & ~abort;

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            data_q <= '1;
            vld_q  <= 1'b0;
         end else begin
            vld_q <= cap;
            if (cap) data_q <= mem_d;
         end
      end

      assign drv_data[k*DW +: DW] = data_q;
      assign drv_valid[k]         = vld_q;
   end

endmodule
